// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : Request/result bundle between the control unit and muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, hi, lo, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO.
//            Optional `MULDIV_FLUSH_EN adds a flush input.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst_n,
`ifdef MULDIV_FLUSH_EN
  input  wire logic flush,
`endif
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  localparam logic [5:0] c_last_iter = 6'(WIDTH - 1);

  state_t               r_state;
  logic [5:0]           r_cnt;
  logic                 r_is_div;
  logic                 r_dbz_pend;
  logic                 r_neg_lo;
  logic                 r_neg_hi;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     r_b;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_dbz;

  logic                 w_rs_neg;
  logic                 w_rt_neg;
  logic [WIDTH-1:0]     w_rs_mag;
  logic [WIDTH-1:0]     w_rt_mag;
  logic                 w_dbz;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_shl;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // op[0] = unsigned, op[1] = divide
  assign w_rs_neg = ~bus.op[0] & bus.rs_data[WIDTH-1];
  assign w_rt_neg = ~bus.op[0] & bus.rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -bus.rs_data : bus.rs_data;
  assign w_rt_mag = w_rt_neg ? -bus.rt_data : bus.rt_data;
  assign w_dbz    = bus.op[1] & (bus.rt_data == '0);

  // Shift-add: multiplier sits in the low half and drains out to the right.
  assign w_sum      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_next = r_p[0] ? {w_sum, r_p[WIDTH-1:1]} : {1'b0, r_p[2*WIDTH-1:1]};

  // Restoring divide: {remainder, quotient} shifts left one bit per step.
  assign w_shl      = r_p[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_shl - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH] ? {w_shl[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_lo ? -r_p : r_p;
  assign w_quo_fix  = r_neg_lo ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_p        <= '0;
      r_b        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
`ifdef MULDIV_FLUSH_EN
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_is_div   <= bus.op[1];
            r_dbz_pend <= w_dbz;
            r_neg_lo   <= w_rs_neg ^ w_rt_neg;
            r_neg_hi   <= w_rs_neg;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= w_dbz ? S_SIGN : S_RUN;
            if (bus.op[1]) begin
              // A zero divisor keeps the raw dividend, which becomes HI.
              r_p <= {{WIDTH{1'b0}}, (w_dbz ? bus.rs_data : w_rs_mag)};
              r_b <= w_rt_mag;
            end else begin
              r_p <= {{WIDTH{1'b0}}, w_rt_mag};
              r_b <= w_rs_mag;
            end
          end
        end
        S_RUN: begin
          r_p <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == c_last_iter) begin
            r_cnt   <= '0;
            r_state <= S_SIGN;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_SIGN: begin
          if (r_dbz_pend) begin
            r_hi  <= r_p[WIDTH-1:0];
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else if (r_is_div) begin
            r_hi  <= w_rem_fix;
            r_lo  <= w_quo_fix;
            r_dbz <= 1'b0;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
            r_dbz        <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
`ifdef MULDIV_FLUSH_EN
      end
`endif
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed and random checks of muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int c_width = 32;

  logic clk;
  logic rst_n;
`ifdef MULDIV_FLUSH_EN
  logic flush;
`endif

  muldiv_unit_if #(.WIDTH(c_width)) bus ();

  muldiv_unit #(.WIDTH(c_width)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MULDIV_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_dbz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sp, sa, sb, sq, sr;
    longint unsigned up;
    dbz = 1'b0;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32]; lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
        end else if (op == 2'b10) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          sq = sa / sb; sr = sa % sb;
          hi = sr[31:0]; lo = sq[31:0];
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endtask

  // Drive start now, take the capture edge, then scramble the inputs.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.rs_data = $urandom; bus.rt_data = $urandom;
    chk("busy_at_capture", {63'd0, bus.busy}, 64'd1);
    chk("done_low_at_capture", {63'd0, bus.done}, 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [31:0] e_hi, e_lo;
    logic        e_dbz;
    int          cyc;
    int          lat;
    model(op, a, b, e_hi, e_lo, e_dbz);
    lat = e_dbz ? 1 : 33;
    issue(op, a, b);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      chk("hold_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("hold_lo", {32'd0, bus.lo}, {32'd0, m_lo});
      if (inject && cyc == 9) begin
        bus.start = 1'b1; bus.op = 2'($urandom);
        bus.rs_data = $urandom; bus.rt_data = $urandom;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.done === 1'b1) chk("busy_done_excl", {63'd0, bus.busy}, 64'd0);
    end
    chk("latency", 64'(cyc), 64'(lat));
    chk("hi", {32'd0, bus.hi}, {32'd0, e_hi});
    chk("lo", {32'd0, bus.lo}, {32'd0, e_lo});
    chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e_dbz});
    m_hi = e_hi; m_lo = e_lo; m_dbz = e_dbz;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_cmp = 0; n_fail = 0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
`ifdef MULDIV_FLUSH_EN
    flush = 1'b0;
`endif
    #12;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    chk("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases; each issue lands in the done cycle of the previous one.
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 1'b0);
    run_op(2'b01, 32'd3, 32'd4, 1'b0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'd0, 1'b0);

    @(posedge clk); #1;
    chk("done_falls", {63'd0, bus.done}, 64'd0);
    chk("idle_busy", {63'd0, bus.busy}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        chk("idle_done_low", {63'd0, bus.done}, 64'd0);
      end
    end

    // Asynchronous reset in the middle of RUN.
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_done", {63'd0, bus.done}, 64'd0);
    chk("midrst_hi", {32'd0, bus.hi}, 64'd0);
    chk("midrst_lo", {32'd0, bus.lo}, 64'd0);
    chk("midrst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("postrst_done", {63'd0, bus.done}, 64'd0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

`ifdef MULDIV_FLUSH_EN
    issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0101);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, bus.busy}, 64'd0);
    chk("flush_done", {63'd0, bus.done}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("flush_no_done", {63'd0, bus.done}, 64'd0);
      chk("flush_hold_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("flush_hold_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    end
    flush = 1'b1; bus.start = 1'b1; bus.op = 2'b01;
    bus.rs_data = 32'd5; bus.rt_data = 32'd6;
    @(posedge clk); #1;
    flush = 1'b0; bus.start = 1'b0;
    chk("flush_start_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    chk("flush_start_idle", {63'd0, bus.busy}, 64'd0);
    run_op(2'b11, 32'd1000, 32'd7, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
